param_updn_counter: RTL and testbench



---
 rtl/updn_pkg.sv | 14 +
 rtl/param_updn_counter_if.sv | 32 +++
 rtl/updn_next.sv | 44 ++++
 rtl/param_updn_counter.sv | 70 +++++++
 tb/tb_param_updn_counter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/updn_pkg.sv
// Shared constants for the up/down counter family.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Direction encodings drive the ud input; mode encodings drive the sat input.
package updn_pkg;

    localparam logic UD_UP     = 1'b1;
    localparam logic UD_DOWN   = 1'b0;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/param_updn_counter_if.sv
// Control/status bundle of param_updn_counter.
// Latency: n/a (wires only).
// Backpressure: none; the counter samples en/ud/sat every clock.
//
// Signals: en (count enable), ud (1 = up), sat (1 = saturate, 0 = wrap),
//          load/d (parallel load, only with COUNTER_LOAD_EN defined),
//          q (count), tc (terminal count, combinational), co (carry/borrow pulse).
// master: the side driving the controls; slave: the counter itself.
interface param_updn_counter_if #(
    parameter int WIDTH = 4
);

    logic             en;
    logic             ud;
    logic             sat;
`ifdef COUNTER_LOAD_EN
    logic             load;
    logic [WIDTH-1:0] d;
`endif
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             co;

`ifdef COUNTER_LOAD_EN
    modport master (output en, ud, sat, load, d, input q, tc, co);
    modport slave  (input en, ud, sat, load, d, output q, tc, co);
`else
    modport master (output en, ud, sat, input q, tc, co);
    modport slave  (input en, ud, sat, output q, tc, co);
`endif

endinterface

// File: rtl/updn_next.sv
// Next-count and wrap-flag calculator for a 0..MAX up/down counter.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: q (current count, assumed within 0..MAX), ud (direction), sat (mode),
//        q_next (count after one step), wrap (this step crosses the boundary).
// At the boundary, saturate mode returns q unchanged and wrap stays low.
module updn_next
    import updn_pkg::*;
#(
    parameter int          WIDTH = 4,
    parameter int unsigned MAX   = (2 ** WIDTH) - 1
) (
    input  logic [WIDTH-1:0] q,
    input  logic             ud,
    input  logic             sat,
    output logic [WIDTH-1:0] q_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    always_comb begin
        q_next = q;
        wrap   = 1'b0;
        if (ud == UD_UP) begin
            // q never exceeds MAX, so "not MAX" means "below MAX" and +1 cannot overflow.
            if (q != MAX_V) begin
                q_next = q + WIDTH'(1);
            end else if (sat == MODE_WRAP) begin
                q_next = '0;
                wrap   = 1'b1;
            end
        end else begin
            if (q != '0) begin
                q_next = q - WIDTH'(1);
            end else if (sat == MODE_WRAP) begin
                q_next = MAX_V;
                wrap   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_updn_counter.sv
// Parametrised synchronous up/down counter, 0..MAX, wrap or saturate at the boundary.
// Latency: q and co update one clock after the controls are sampled; tc is combinational.
// Backpressure: none; en low simply holds the count.
//
// Ports: clk, reset (synchronous, active high), bus (param_updn_counter_if.slave).
// Optional feature macro: COUNTER_LOAD_EN adds bus.load/bus.d parallel load,
// which outranks counting; loaded values above MAX are clamped to MAX.
// Cascading: feed tc of one stage into en of the next, sharing ud/sat/clk.
module param_updn_counter
    import updn_pkg::*;
#(
    parameter int          WIDTH = 4,
    parameter int unsigned MAX   = (2 ** WIDTH) - 1
) (
    input  logic                 clk,
    input  logic                 reset,
    param_updn_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             co_r;
    logic             co_nxt;
    logic             wrap;

    updn_next #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_next (
        .q      (q_r),
        .ud     (bus.ud),
        .sat    (bus.sat),
        .q_next (cnt_nxt),
        .wrap   (wrap)
    );

    // Priority mux below reset: load, then enable/count; co only pulses on a wrap.
    always_comb begin
        q_nxt  = q_r;
        co_nxt = 1'b0;
`ifdef COUNTER_LOAD_EN
        if (bus.load) begin
            q_nxt = (bus.d > MAX_V) ? MAX_V : bus.d;
        end else
`endif
        if (bus.en) begin
            q_nxt  = cnt_nxt;
            co_nxt = wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r  <= '0;
            co_r <= 1'b0;
        end else begin
            q_r  <= q_nxt;
            co_r <= co_nxt;
        end
    end

    assign bus.q  = q_r;
    assign bus.co = co_r;
    assign bus.tc = bus.en & (((bus.ud == UD_UP)   && (q_r == MAX_V)) ||
                              ((bus.ud == UD_DOWN) && (q_r == '0)));

endmodule

// File: tb/tb_param_updn_counter.sv
// Bench for param_updn_counter: a 4-bit mod-16 instance (a) and a
// two-stage decade cascade (b drives c through tc->en).
// Expected values come from a rule-level reference model of the count sequence.
module tb_param_updn_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, ud, sat, en_a, en_b;
`ifdef COUNTER_LOAD_EN
    logic       load;
    logic [3:0] d;
`endif

    param_updn_counter_if #(.WIDTH(4)) bus_a ();
    param_updn_counter_if #(.WIDTH(4)) bus_b ();
    param_updn_counter_if #(.WIDTH(4)) bus_c ();

    assign bus_a.en = en_a;
    assign bus_b.en = en_b;
    assign bus_c.en = bus_b.tc;
    assign bus_a.ud = ud;
    assign bus_b.ud = ud;
    assign bus_c.ud = ud;
    assign bus_a.sat = sat;
    assign bus_b.sat = sat;
    assign bus_c.sat = sat;
`ifdef COUNTER_LOAD_EN
    assign bus_a.load = load;
    assign bus_b.load = load;
    assign bus_c.load = load;
    assign bus_a.d = d;
    assign bus_b.d = d;
    assign bus_c.d = d;
`endif

    param_updn_counter #(.WIDTH(4), .MAX(15)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    param_updn_counter #(.WIDTH(4), .MAX(9))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    param_updn_counter #(.WIDTH(4), .MAX(9))  dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    logic [3:0] oq [3];
    logic       oco[3];
    logic       otc[3];
    assign oq[0] = bus_a.q;  assign oco[0] = bus_a.co;  assign otc[0] = bus_a.tc;
    assign oq[1] = bus_b.q;  assign oco[1] = bus_b.co;  assign otc[1] = bus_b.tc;
    assign oq[2] = bus_c.q;  assign oco[2] = bus_c.co;  assign otc[2] = bus_c.tc;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers, one entry per counter.
    int mq [3];
    bit mco[3];
    int mmax[3] = '{15, 9, 9};

    function automatic bit m_tc(int q, bit en, bit up, int mx);
        return en && ((up && q == mx) || (!up && q == 0));
    endfunction

    function automatic bit m_en(int i);
        if (i == 0) return en_a;
        if (i == 1) return en_b;
        return m_tc(mq[1], en_b, ud, mmax[1]);
    endfunction

    function automatic bit exp_tc(int i);
        return m_tc(mq[i], m_en(i), ud, mmax[i]);
    endfunction

    // One clock: capture the controls, let the edge pass, then apply the counting rules.
    task automatic tick();
        bit en_now[3];
        bit rst_now, up_now, sat_now, ld_now;
        int dv;
        for (int i = 0; i < 3; i++) en_now[i] = m_en(i);
        rst_now = reset; up_now = ud; sat_now = sat;
        ld_now = 1'b0; dv = 0;
`ifdef COUNTER_LOAD_EN
        ld_now = load; dv = int'(d);
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rst_now) begin
                mq[i] = 0; mco[i] = 0;
            end else if (ld_now) begin
                mq[i] = (dv > mmax[i]) ? mmax[i] : dv; mco[i] = 0;
            end else if (!en_now[i]) begin
                mco[i] = 0;
            end else if (up_now) begin
                if (mq[i] < mmax[i])  begin mq[i] = mq[i] + 1; mco[i] = 0; end
                else if (sat_now)     begin mco[i] = 0; end
                else                  begin mq[i] = 0; mco[i] = 1; end
            end else begin
                if (mq[i] > 0)        begin mq[i] = mq[i] - 1; mco[i] = 0; end
                else if (sat_now)     begin mco[i] = 0; end
                else                  begin mq[i] = mmax[i]; mco[i] = 1; end
            end
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; en_a = 1'b0; en_b = 1'b0; ud = 1'b1; sat = 1'b0;
`ifdef COUNTER_LOAD_EN
        load = 1'b0; d = 4'd0;
`endif
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0; en_a = 1'b1; ud = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (oq[i] !== 4'd0) begin
                errors++; $display("FAIL reset_q[%0d]: got %0d want 0", i, oq[i]);
            end
            checks++;
            if (oco[i] !== 1'b0) begin
                errors++; $display("FAIL reset_co[%0d]: got %b want 0", i, oco[i]);
            end
        end
        checks++;
        if (otc[0] !== 1'b1) begin
            errors++; $display("FAIL reset_tc: got %b want 1", otc[0]);
        end
    endtask

    task automatic test_count_up();
        idle_inputs();
        reset = 1'b1; tick(); reset = 1'b0;
        en_a = 1'b1; ud = 1'b1; sat = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            tick();
            checks++;
            if (oq[0] !== 4'(c % 16)) begin
                errors++; $display("FAIL up_q cycle %0d: got %0d want %0d", c, oq[0], c % 16);
            end
            checks++;
            if (oco[0] !== 1'(c == 16)) begin
                errors++; $display("FAIL up_co cycle %0d: got %b want %b", c, oco[0], c == 16);
            end
            checks++;
            if (otc[0] !== 1'(c == 15)) begin
                errors++; $display("FAIL up_tc cycle %0d: got %b want %b", c, otc[0], c == 15);
            end
        end
    endtask

    task automatic test_down_boundary();
        idle_inputs();
        reset = 1'b1; tick(); reset = 1'b0;
        en_a = 1'b1; ud = 1'b0; sat = 1'b0;
        tick();
        checks++;
        if (oq[0] !== 4'd15 || oco[0] !== 1'b1) begin
            errors++; $display("FAIL down_wrap: got q=%0d co=%b want q=15 co=1", oq[0], oco[0]);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        sat = 1'b1;
        tick();
        checks++;
        if (oq[0] !== 4'd0 || oco[0] !== 1'b0 || otc[0] !== 1'b1) begin
            errors++;
            $display("FAIL down_sat: got q=%0d co=%b tc=%b want q=0 co=0 tc=1", oq[0], oco[0], otc[0]);
        end
    endtask

    task automatic test_decade();
        int exp_seq[3] = '{8, 9, 0};
        idle_inputs();
        reset = 1'b1; tick(); reset = 1'b0;
        en_b = 1'b1; ud = 1'b1; sat = 1'b0;
        repeat (7) tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (oq[1] !== 4'(exp_seq[k]) || oco[1] !== 1'(k == 2)) begin
                errors++;
                $display("FAIL decade step %0d: got q=%0d co=%b want q=%0d co=%b",
                         k, oq[1], oco[1], exp_seq[k], k == 2);
            end
            checks++;
            if (oq[2] !== 4'(mq[2])) begin
                errors++; $display("FAIL decade_hi step %0d: got %0d want %0d", k, oq[2], mq[2]);
            end
        end
        repeat (9) tick();
        sat = 1'b1;
        repeat (2) begin
            tick();
            checks++;
            if (oq[1] !== 4'd9 || oco[1] !== 1'b0 || otc[1] !== 1'b1) begin
                errors++;
                $display("FAIL decade_sat: got q=%0d co=%b tc=%b want q=9 co=0 tc=1", oq[1], oco[1], otc[1]);
            end
        end
    endtask

`ifdef COUNTER_LOAD_EN
    task automatic test_load();
        idle_inputs();
        reset = 1'b1; tick(); reset = 1'b0;
        load = 1'b1; d = 4'd12;
        tick();
        checks++;
        if (oq[1] !== 4'd9 || oq[0] !== 4'd12) begin
            errors++; $display("FAIL load_clamp: got b=%0d a=%0d want b=9 a=12", oq[1], oq[0]);
        end
        en_b = 1'b1; d = 4'd3;
        tick();
        checks++;
        if (oq[1] !== 4'd3 || oco[1] !== 1'b0) begin
            errors++; $display("FAIL load_en: got q=%0d co=%b want q=3 co=0", oq[1], oco[1]);
        end
        d = 4'd9;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (oq[1] !== 4'd0 || oco[1] !== 1'b1) begin
            errors++; $display("FAIL load_max_wrap: got q=%0d co=%b want q=0 co=1", oq[1], oco[1]);
        end
    endtask
`endif

    task automatic test_reset_override();
        idle_inputs();
        reset = 1'b1; tick(); reset = 1'b0;
        en_a = 1'b1; ud = 1'b1;
        repeat (6) tick();
        checks++;
        if (oq[0] !== 4'd6) begin
            errors++; $display("FAIL override_pre: got %0d want 6", oq[0]);
        end
        reset = 1'b1;
`ifdef COUNTER_LOAD_EN
        load = 1'b1; d = 4'd11;
`endif
        tick();
        checks++;
        if (oq[0] !== 4'd0 || oco[0] !== 1'b0) begin
            errors++; $display("FAIL override_rst: got q=%0d co=%b want q=0 co=0", oq[0], oco[0]);
        end
        reset = 1'b0;
`ifdef COUNTER_LOAD_EN
        load = 1'b0;
`endif
        tick();
        checks++;
        if (oq[0] !== 4'd1) begin
            errors++; $display("FAIL override_resume: got %0d want 1", oq[0]);
        end
    endtask

    task automatic test_cascade();
        idle_inputs();
        reset = 1'b1; tick(); reset = 1'b0;
        en_b = 1'b1; ud = 1'b1; sat = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            checks++;
            if (oq[1] !== 4'((c % 100) % 10) || oq[2] !== 4'((c % 100) / 10)) begin
                errors++;
                $display("FAIL cascade cycle %0d: got %0d%0d want %0d%0d",
                         c, oq[2], oq[1], (c % 100) / 10, (c % 100) % 10);
            end
        end
        checks++;
        if (oco[2] !== 1'b1) begin
            errors++; $display("FAIL cascade_co: got %b want 1", oco[2]);
        end
    endtask

    task automatic test_random();
        idle_inputs();
        reset = 1'b1; tick();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(31) == 0);
            en_a  = ($urandom_range(3) != 0);
            en_b  = ($urandom_range(3) != 0);
            ud    = 1'($urandom_range(1));
            sat   = ($urandom_range(3) == 0);
`ifdef COUNTER_LOAD_EN
            load  = ($urandom_range(7) == 0);
            d     = 4'($urandom_range(15));
`endif
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (oq[i] !== 4'(mq[i]) || oco[i] !== mco[i] || otc[i] !== exp_tc(i)) begin
                    errors++;
                    $display("FAIL random cycle %0d ctr %0d: got q=%0d co=%b tc=%b want q=%0d co=%b tc=%b",
                             c, i, oq[i], oco[i], otc[i], mq[i], mco[i], exp_tc(i));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_count_up();
        test_down_boundary();
        test_decade();
`ifdef COUNTER_LOAD_EN
        test_load();
`endif
        test_reset_override();
        test_cascade();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
